// File: rtl/regfile_pkg.sv
// Shared definitions for the 32x64 register file: geometry, address/word types,
// read-port FSM encoding and the saturating request counter helper.
package regfile_pkg;

    localparam int WIDTH    = 64;
    localparam int NREGS    = 32;
    localparam int ADDR_W   = $clog2(NREGS);
    localparam int ZERO_IDX = 31;
    localparam int CNT_W    = 16;

    typedef logic [ADDR_W-1:0]            reg_addr_t;
    typedef logic [WIDTH-1:0]             reg_word_t;
    typedef logic [NREGS-1:0][WIDTH-1:0]  reg_array_t;
    typedef logic [CNT_W-1:0]             count_t;

    localparam reg_addr_t ZERO_REG  = reg_addr_t'(ZERO_IDX);
    localparam count_t    COUNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rd_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic count_t sat_inc(input count_t c);
        count_t r;
        if (c == COUNT_MAX) begin
            r = c;
        end else begin
            r = c + count_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_read_port_if.sv
// Request/response handshake bundle between a requester (master) and the
// register-file read unit (slave).
interface regfile_read_port_if;
    import regfile_pkg::*;

    logic      req_valid;
    logic      req_ready;
    reg_addr_t ra1;
    reg_addr_t ra2;
    logic      rsp_valid;
    logic      rsp_ready;
    reg_word_t rd1;
    reg_word_t rd2;
    count_t    read_count;

    modport master (
        output req_valid, ra1, ra2, rsp_ready,
        input  req_ready, rsp_valid, rd1, rd2, read_count
    );

    modport slave (
        input  req_valid, ra1, ra2, rsp_ready,
        output req_ready, rsp_valid, rd1, rd2, read_count
    );

endinterface

// File: rtl/regfile_read_mux.sv
// One operand select: 32:1 array read with hard-wired zero register and
// forwarding of the write that lands at the coming edge.
module regfile_read_mux
    import regfile_pkg::*;
(
    input  reg_array_t regs,
    input  reg_addr_t  ra,
    input  logic       wr_en,
    input  reg_addr_t  wr_addr,
    input  reg_word_t  wr_data,
    output reg_word_t  data
);

    // Zero register wins over forwarding, forwarding wins over the array.
    always_comb begin
        data = '0;
        if (ra == ZERO_REG) begin
            data = '0;
        end else if (wr_en && (wr_addr == ra)) begin
            data = wr_data;
        end else begin
            data = regs[ra];
        end
    end

endmodule

// File: rtl/regfile_read_port.sv
// Dual-operand read unit: one-deep registered output stage with valid/ready
// backpressure and a saturating count of accepted requests.
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  reg_array_t          regs,
    input  logic                wr_en,
    input  reg_addr_t           wr_addr,
    input  reg_word_t           wr_data,
    regfile_read_port_if.slave  bus
);

    rd_state_t state_r;
    rd_state_t state_nxt_s;
    reg_word_t rd1_r;
    reg_word_t rd2_r;
    count_t    count_r;
    count_t    count_nxt_s;
    reg_word_t sel1_s;
    reg_word_t sel2_s;
    logic      rsp_valid_s;
    logic      req_ready_s;
    logic      accept_s;

    regfile_read_mux u_mux1 (
        .regs    (regs),
        .ra      (bus.ra1),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (sel1_s)
    );

    regfile_read_mux u_mux2 (
        .regs    (regs),
        .ra      (bus.ra2),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .data    (sel2_s)
    );

    // Draining the stage in the same cycle frees it for a new request.
    assign rsp_valid_s = (state_r == FULL);
    assign req_ready_s = !rsp_valid_s || bus.rsp_ready;
    assign accept_s    = bus.req_valid && req_ready_s;

    // Next-state and counter update.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        if (accept_s) begin
            count_nxt_s = sat_inc(count_r);
        end else begin
            count_nxt_s = count_r;
        end
        case (state_r)
            EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = EMPTY;
                end
            end
            FULL: begin
                if (bus.rsp_ready && !accept_s) begin
                    state_nxt_s = EMPTY;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = EMPTY;
            end
        endcase
    end

    // State, snapshot registers and counter; operands only move on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= EMPTY;
            rd1_r   <= '0;
            rd2_r   <= '0;
            count_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            if (accept_s) begin
                rd1_r <= sel1_s;
                rd2_r <= sel2_s;
            end
        end
    end

    assign bus.rsp_valid  = rsp_valid_s;
    assign bus.req_ready  = req_ready_s;
    assign bus.rd1        = rd1_r;
    assign bus.rd2        = rd2_r;
    assign bus.read_count = count_r;

endmodule

// File: tb/tb_regfile_read_port.sv
// Self-checking bench for regfile_read_port: table of operand-select vectors
// scored through a response queue, plus stall, reset and saturation sequences.
module tb_regfile_read_port;
    import regfile_pkg::*;

    logic       clk;
    logic       reset;
    reg_array_t regs;
    logic       wr_en;
    reg_addr_t  wr_addr;
    reg_word_t  wr_data;

    regfile_read_port_if bus ();

    regfile_read_port dut (
        .clk     (clk),
        .reset   (reset),
        .regs    (regs),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    typedef struct {
        reg_addr_t ra1;
        reg_addr_t ra2;
        logic      we;
        reg_addr_t wa;
        reg_word_t wd;
        reg_word_t exp1;
        reg_word_t exp2;
    } vec_t;

    typedef struct packed {
        reg_word_t e1;
        reg_word_t e2;
    } exp_t;

    vec_t vecs [9];
    exp_t sb_q [$];
    int   errors;
    int   checks;
    logic sb_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_en && !reset && bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got rd1=%h with no expected entry", bus.rd1);
                end else begin
                    e = sb_q.pop_front();
                    check("rd1", bus.rd1, e.e1);
                    check("rd2", bus.rd2, e.e2);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        sb_en  = 1'b1;
        reset  = 1'b1;
        wr_en  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        bus.req_valid = 1'b0;
        bus.ra1 = '0;
        bus.ra2 = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < NREGS; i++) regs[i] = 64'h100 + 64'(i);
        regs[4]  = 64'd27;
        regs[0]  = 64'd2147483647;
        regs[31] = 64'd1;

        vecs[0] = '{5'd4,  5'd0,  1'b0, 5'd0,  64'd0,        64'd27,       64'd2147483647};
        vecs[1] = '{5'd31, 5'd31, 1'b0, 5'd0,  64'd0,        64'd0,        64'd0};
        vecs[2] = '{5'd31, 5'd31, 1'b1, 5'd31, 64'd5,        64'd0,        64'd0};
        vecs[3] = '{5'd4,  5'd7,  1'b1, 5'd4,  64'd44,       64'd44,       64'h107};
        vecs[4] = '{5'd4,  5'd4,  1'b1, 5'd5,  64'd44,       64'd27,       64'd27};
        vecs[5] = '{5'd5,  5'd5,  1'b1, 5'd5,  64'hDEAD,     64'hDEAD,     64'hDEAD};
        vecs[6] = '{5'd30, 5'd1,  1'b0, 5'd0,  64'd0,        64'h11E,      64'h101};
        vecs[7] = '{5'd30, 5'd31, 1'b1, 5'd30, 64'h77,       64'h77,       64'd0};
        vecs[8] = '{5'd2,  5'd3,  1'b0, 5'd2,  64'h99,       64'h102,      64'h103};

        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_rd1", bus.rd1, 64'd0);
        check("rst_rd2", bus.rd2, 64'd0);
        check("rst_count", 64'(bus.read_count), 64'd0);

        // Table: back-to-back requests, no backpressure
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            bus.req_valid = 1'b1;
            bus.ra1 = vecs[i].ra1;
            bus.ra2 = vecs[i].ra2;
            wr_en   = vecs[i].we;
            wr_addr = vecs[i].wa;
            wr_data = vecs[i].wd;
            sb_q.push_back('{vecs[i].exp1, vecs[i].exp2});
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
        check("count_after_table", 64'(bus.read_count), 64'd9);

        // Stall: snapshot must hold while array and write bus change
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.ra1 = 5'd4;
        bus.ra2 = 5'd0;
        bus.rsp_ready = 1'b0;
        sb_q.push_back('{64'd27, 64'd2147483647});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        regs[4] = 64'd44;
        wr_en = 1'b1;
        wr_addr = 5'd4;
        wr_data = 64'd55;
        repeat (3) begin
            @(negedge clk);
            check("stall_rd1", bus.rd1, 64'd27);
            check("stall_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            check("stall_req_ready", 64'(bus.req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.ra1 = 5'd4;
        bus.ra2 = 5'd4;
        sb_q.push_back('{64'd44, 64'd44});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("b2b_count", 64'(bus.read_count), 64'd11);

        // Asynchronous reset while a response is held
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.ra1 = 5'd7;
        bus.ra2 = 5'd8;
        bus.rsp_ready = 1'b0;
        sb_q.push_back('{64'h107, 64'h108});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        #10 reset = 1'b1;
        #1;
        check("async_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("async_rst_rd1", bus.rd1, 64'd0);
        check("async_rst_rd2", bus.rd2, 64'd0);
        check("async_rst_count", 64'(bus.read_count), 64'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("post_rst_rd1", bus.rd1, 64'd0);

        // Counter saturation
        sb_en = 1'b0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.ra1 = 5'd0;
        bus.ra2 = 5'd0;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("count_fffe", 64'(bus.read_count), 64'hFFFE);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("count_sat", 64'(bus.read_count), 64'hFFFF);
        end
        bus.req_valid = 1'b0;

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
